// File: rtl/char_text_buffer.sv
// char_text_buffer: 16x32 grid of 7-bit character codes feeding the overlay
// stage. One synchronous read port serves the overlay. A single write port
// is shared by direct character pokes, a 4-digit decimal printer and a
// full-screen clear sequencer.
module char_text_buffer #(
  parameter logic [6:0]  CLEAR_CHAR = 7'h20,
  parameter logic [13:0] NUM_MAX    = 14'd9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  char_xy,
  input  logic [3:0]  char_line,
  output logic [6:0]  char_code,
  output logic [3:0]  char_line_out,
  input  logic        wr_en,
  input  logic [8:0]  wr_addr,
  input  logic [6:0]  wr_data,
  input  logic        num_start,
  input  logic [8:0]  num_addr,
  input  logic [13:0] num_value,
  input  logic        clr_start,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    D3,
    D2,
    D1,
    D0
  } state_t;

  localparam logic [13:0] W1000 = 14'd1000;
  localparam logic [13:0] W100  = 14'd100;
  localparam logic [13:0] W10   = 14'd10;

  // Clamp a value to the largest printable number.
  function automatic logic [13:0] sat_num(input logic [13:0] v);
    return (v > NUM_MAX) ? NUM_MAX : v;
  endfunction

  // ASCII code of a decimal digit 0..9.
  function automatic logic [6:0] digit_char(input logic [3:0] d);
    return 7'h30 + {3'b000, d};
  endfunction

  // Character storage; power-up content is the clear character.
  logic [6:0] ram [512] = '{default: CLEAR_CHAR};

  state_t      state;
  logic [8:0]  ptr;
  logic [8:0]  base;
  logic [13:0] rem;
  logic [3:0]  cnt;

  logic [13:0] weight;
  logic [8:0]  dig_ofs;
  logic        dig_done;

  logic        ram_we_p0;
  logic [8:0]  ram_addr_p0;
  logic [6:0]  ram_din_p0;

  // ---- stage p0: select the write source for this cycle ----
  // Weight and cell offset of the digit currently being counted.
  always_comb begin
    weight  = W1000;
    dig_ofs = 9'd0;
    case (state)
      D2: begin
        weight  = W100;
        dig_ofs = 9'd1;
      end
      D1: begin
        weight  = W10;
        dig_ofs = 9'd2;
      end
      default: ;
    endcase
  end

  assign dig_done = (rem < weight);

  // Multiplex pokes, digit emission and clear onto the single write port.
  always_comb begin
    ram_we_p0   = 1'b0;
    ram_addr_p0 = wr_addr;
    ram_din_p0  = wr_data;
    case (state)
      IDLE: begin
        ram_we_p0 = wr_en & ~clr_start & ~num_start;
      end
      CLEAR: begin
        ram_we_p0   = 1'b1;
        ram_addr_p0 = ptr;
        ram_din_p0  = CLEAR_CHAR;
      end
      D3, D2, D1: begin
        ram_we_p0   = dig_done;
        ram_addr_p0 = base + dig_ofs;
        ram_din_p0  = digit_char(cnt);
      end
      D0: begin
        ram_we_p0   = 1'b1;
        ram_addr_p0 = base + 9'd3;
        ram_din_p0  = digit_char(rem[3:0]);
      end
      default: ;
    endcase
    if (rst) begin
      ram_we_p0 = 1'b0;
    end
  end

  // ---- stage p1: memory write and registered read ----
  // Write port; the non-blocking update keeps same-cycle reads read-first.
  always_ff @(posedge clk) begin
    if (ram_we_p0) begin
      ram[ram_addr_p0] <= ram_din_p0;
    end
  end

  // Read port plus glyph-line delay so both arrive at the font ROM together.
  always_ff @(posedge clk) begin
    if (rst) begin
      char_code     <= 7'h00;
      char_line_out <= 4'h0;
    end else begin
      char_code     <= ram[char_xy];
      char_line_out <= char_line;
    end
  end

  // Command sequencer: clear sweep and repeated-subtraction digit counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= 4'd0;
      rem   <= 14'd0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_start) begin
            ptr   <= 9'd0;
            state <= CLEAR;
            busy  <= 1'b1;
          end else if (num_start) begin
            base  <= num_addr;
            rem   <= sat_num(num_value);
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          ptr <= ptr + 9'd1;
          if (ptr == 9'd511) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        LOAD: begin
          cnt   <= 4'd0;
          state <= D3;
        end
        D3, D2, D1: begin
          if (!dig_done) begin
            rem <= rem - weight;
            cnt <= cnt + 4'd1;
          end else begin
            cnt <= 4'd0;
            case (state)
              D3:      state <= D2;
              D2:      state <= D1;
              default: state <= D0;
            endcase
          end
        end
        D0: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_text_buffer.sv
// Directed bench for char_text_buffer: table-driven pokes and number prints,
// plus hand-written sequences for reset, read-first, clear and reset mid-print.
module tb_char_text_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  char_xy;
  logic [3:0]  char_line;
  logic [6:0]  char_code;
  logic [3:0]  char_line_out;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [6:0]  wr_data;
  logic        num_start;
  logic [8:0]  num_addr;
  logic [13:0] num_value;
  logic        clr_start;
  logic        busy;

  int total = 0;
  int bad   = 0;

  char_text_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .char_xy      (char_xy),
    .char_line    (char_line),
    .char_code    (char_code),
    .char_line_out(char_line_out),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .num_start    (num_start),
    .num_addr     (num_addr),
    .num_value    (num_value),
    .clr_start    (clr_start),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] addr;
    logic [6:0] data;
    logic [3:0] line;
  } wr_vec_t;

  typedef struct {
    logic [8:0]  addr;
    logic [13:0] value;
    logic [27:0] digits;
    int          len;
  } num_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns the cell content one cycle later.
  task automatic read_cell(input logic [8:0] a, output logic [6:0] c);
    char_xy = a;
    @(posedge clk);
    @(negedge clk);
    c = char_code;
  endtask

  task automatic do_print(input logic [8:0] a, input logic [13:0] v,
                          output logic first_busy, output int len);
    num_start = 1'b1;
    num_addr  = a;
    num_value = v;
    @(negedge clk);
    num_start  = 1'b0;
    first_busy = busy;
    len = 0;
    while (busy === 1'b1 && len < 600) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic poke(input logic [8:0] a, input logic [6:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wr_vec_t    wv [4];
    num_vec_t   nv [6];
    logic [6:0] c;
    logic       fb;
    int         len;
    int         nbad;

    wv[0] = '{9'h000, 7'h41, 4'h1};
    wv[1] = '{9'h1FF, 7'h7F, 4'hF};
    wv[2] = '{9'h0AA, 7'h00, 4'h6};
    wv[3] = '{9'h155, 7'h2A, 4'h9};

    nv[0] = '{9'h010, 14'd3072,  {7'h33, 7'h30, 7'h37, 7'h32}, 15};
    nv[1] = '{9'h1FE, 14'd16383, {7'h39, 7'h39, 7'h39, 7'h39}, 32};
    nv[2] = '{9'h100, 14'd0,     {7'h30, 7'h30, 7'h30, 7'h30}, 5};
    nv[3] = '{9'h1FD, 14'd4567,  {7'h34, 7'h35, 7'h36, 7'h37}, 20};
    nv[4] = '{9'h060, 14'd1005,  {7'h31, 7'h30, 7'h30, 7'h35}, 6};
    nv[5] = '{9'h070, 14'd10000, {7'h39, 7'h39, 7'h39, 7'h39}, 32};

    rst = 1'b1; char_xy = 9'h000; char_line = 4'h5;
    wr_en = 1'b0; wr_addr = 9'h000; wr_data = 7'h00;
    num_start = 1'b0; num_addr = 9'h000; num_value = 14'd0; clr_start = 1'b0;

    // Reset values and first read.
    repeat (3) @(negedge clk);
    check("rst_char_code", char_code, 7'h00);
    check("rst_line_out", char_line_out, 4'h0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_code", char_code, 7'h20);
    check("post_rst_line", char_line_out, 4'h5);
    char_line = 4'hA;
    @(negedge clk);
    check("line_lag", char_line_out, 4'hA);

    // Same-cycle read of the written cell returns the old content.
    char_xy = 9'h025;
    wr_en = 1'b1; wr_addr = 9'h025; wr_data = 7'h41;
    @(negedge clk);
    wr_en = 1'b0;
    check("read_first", char_code, 7'h20);
    @(negedge clk);
    check("write_visible", char_code, 7'h41);

    // Table of single-character writes.
    for (int i = 0; i < 4; i++) begin
      char_xy = 9'h025;
      char_line = wv[i].line;
      poke(wv[i].addr, wv[i].data);
      read_cell(wv[i].addr, c);
      check($sformatf("wr_cell_%0d", i), c, wv[i].data);
      check($sformatf("wr_line_%0d", i), char_line_out, wv[i].line);
    end

    // Table of number prints.
    for (int i = 0; i < 6; i++) begin
      do_print(nv[i].addr, nv[i].value, fb, len);
      check($sformatf("num_busy_rise_%0d", i), fb, 1'b1);
      check($sformatf("num_busy_len_%0d", i), len, nv[i].len);
      for (int k = 0; k < 4; k++) begin
        read_cell(nv[i].addr + 9'(k), c);
        check($sformatf("num_%0d_digit_%0d", i, k), c, nv[i].digits[27-7*k -: 7]);
      end
    end

    // Reset during a print of 9999: only the first digit has been written.
    poke(9'h0A0, 7'h61);
    poke(9'h0A1, 7'h62);
    poke(9'h0A2, 7'h63);
    poke(9'h0A3, 7'h64);
    num_start = 1'b1; num_addr = 9'h0A0; num_value = 14'd9999;
    @(negedge clk);
    num_start = 1'b0;
    repeat (11) @(negedge clk);
    check("midprint_busy_before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midprint_busy_after", busy, 1'b0);
    read_cell(9'h0A0, c); check("midprint_cell0", c, 7'h39);
    read_cell(9'h0A1, c); check("midprint_cell1", c, 7'h62);
    read_cell(9'h0A2, c); check("midprint_cell2", c, 7'h63);
    read_cell(9'h0A3, c); check("midprint_cell3", c, 7'h64);

    // Clear has priority over print; strobes during the clear are ignored.
    clr_start = 1'b1; num_start = 1'b1; num_addr = 9'h000; num_value = 14'd1234;
    @(negedge clk);
    clr_start = 1'b0; num_start = 1'b0;
    len = 0;
    while (busy === 1'b1 && len < 2000) begin
      len++;
      wr_en = 1'b0;
      num_start = 1'b0;
      if (len == 100) begin
        wr_en = 1'b1; wr_addr = 9'h010; wr_data = 7'h55;
      end else if (len == 101) begin
        num_start = 1'b1; num_addr = 9'h1F0; num_value = 14'd5;
      end
      @(negedge clk);
    end
    wr_en = 1'b0; num_start = 1'b0;
    check("clear_busy_len", len, 512);
    check("clear_idle_after", busy, 1'b0);
    read_cell(9'h010, c);
    check("clear_ignored_wr", c, 7'h20);
    nbad = 0;
    for (int a = 0; a < 512; a++) begin
      read_cell(9'(a), c);
      if (c !== 7'h20) nbad++;
    end
    check("clear_all_cells_bad_count", nbad, 0);

    // A fresh command is accepted right after the clear.
    do_print(9'h020, 14'd42, fb, len);
    check("after_clear_len", len, 1 + 1 + 1 + 5 + 1);
    read_cell(9'h022, c);
    check("after_clear_digit", c, 7'h34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
